// File: rtl/esm_buffer_writer.sv
// ESM shared buffer, write side.
// Stores each incoming word in the lowest-index free slot. Publishes the
// per-slot occupancy as cand_list. Serves indexed reads, each of which frees
// the slot it reads.
module esm_buffer_writer #(
  parameter int bs = 16,
  parameter int dw = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [dw-1:0]          in_data,
  output logic                   in_ready,
  input  logic                   rd_en,
  input  logic [$clog2(bs)-1:0]  rd_index,
  output logic                   rd_valid,
  output logic [dw-1:0]          rd_data,
  output logic [bs-1:0]          cand_list,
  output logic [$clog2(bs):0]    count,
  output logic                   full,
  output logic                   empty,
  output logic                   rd_err
);

  localparam int IW = $clog2(bs);
  localparam int CW = $clog2(bs) + 1;

  logic [bs-1:0] occ_r;
  logic [dw-1:0] mem_r [bs];
  logic [CW-1:0] count_r;
  logic          rd_valid_r;
  logic          rd_err_r;
  logic [dw-1:0] rd_data_r;

  logic [IW-1:0] wr_slot_s;
  logic          wr_fire_s;
  logic          rd_in_range_s;
  logic [IW-1:0] rd_idx_safe_s;
  logic          rd_legal_s;
  logic          rd_illegal_s;
  logic [bs-1:0] occ_next_s;

  // Lowest-index free slot; scanning downward lets the lowest free index win.
  always_comb begin
    wr_slot_s = {IW{1'b0}};
    for (int i = bs - 1; i >= 0; i--) begin
      if (!occ_r[i]) begin
        wr_slot_s = IW'(i);
      end else begin
        wr_slot_s = wr_slot_s;
      end
    end
  end

  // Handshake and read legality, all from registered state plus current inputs.
  always_comb begin
    full          = (count_r == CW'(bs));
    empty         = (count_r == {CW{1'b0}});
    // Ready is held low while reset is asserted; otherwise it is simply !full.
    in_ready      = !full && !rst;
    wr_fire_s     = in_valid && in_ready;
    rd_in_range_s = (int'(rd_index) < bs);
    // Out-of-range indices are steered to slot 0 so occupancy is never indexed
    // outside the vector; legality still rejects them.
    if (rd_in_range_s) begin
      rd_idx_safe_s = rd_index;
    end else begin
      rd_idx_safe_s = {IW{1'b0}};
    end
    rd_legal_s    = rd_en && rd_in_range_s && occ_r[rd_idx_safe_s];
    rd_illegal_s  = rd_en && !rd_legal_s;
  end

  // Next occupancy: set the write slot, clear the read slot. They never collide.
  always_comb begin
    occ_next_s = occ_r;
    if (wr_fire_s) begin
      occ_next_s[wr_slot_s] = 1'b1;
    end else begin
      occ_next_s = occ_next_s;
    end
    if (rd_legal_s) begin
      occ_next_s[rd_idx_safe_s] = 1'b0;
    end else begin
      occ_next_s = occ_next_s;
    end
  end

  // Occupancy, count and read-side registers; async reset drops all transfers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_r      <= {bs{1'b0}};
      count_r    <= {CW{1'b0}};
      rd_valid_r <= 1'b0;
      rd_err_r   <= 1'b0;
      rd_data_r  <= {dw{1'b0}};
    end else begin
      occ_r      <= occ_next_s;
      count_r    <= count_r + CW'(wr_fire_s) - CW'(rd_legal_s);
      rd_valid_r <= rd_legal_s;
      rd_err_r   <= rd_illegal_s;
      if (rd_legal_s) begin
        rd_data_r <= mem_r[rd_idx_safe_s];
      end else begin
        rd_data_r <= rd_data_r;
      end
    end
  end

  // Storage array; contents are meaningful only where occupancy is set.
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      mem_r[wr_slot_s] <= in_data;
    end else begin
      mem_r[wr_slot_s] <= mem_r[wr_slot_s];
    end
  end

  assign cand_list = occ_r;
  assign count     = count_r;
  assign rd_valid  = rd_valid_r;
  assign rd_data   = rd_data_r;
  assign rd_err    = rd_err_r;

endmodule

// File: tb/tb_esm_buffer_writer.sv
// Self-checking bench for esm_buffer_writer: directed scenarios with literal
// expectations, followed by randomized traffic against a slot-level model.
module tb_esm_buffer_writer;

  localparam int BS = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          rd_en = 1'b0;
  logic [3:0]    rd_index = '0;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [BS-1:0] cand_list;
  logic [4:0]    count;
  logic          full;
  logic          empty;
  logic          rd_err;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Model: a set of occupied slots with their stored words, plus read results.
  bit            m_occ [BS];
  logic [DW-1:0] m_mem [BS];
  bit            m_rv;
  bit            m_re;
  logic [DW-1:0] m_rd;

  esm_buffer_writer #(.bs(BS), .dw(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .rd_en(rd_en), .rd_index(rd_index),
    .rd_valid(rd_valid), .rd_data(rd_data), .cand_list(cand_list),
    .count(count), .full(full), .empty(empty), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < BS; i++) n += m_occ[i];
    return n;
  endfunction

  function automatic logic [BS-1:0] m_cand();
    logic [BS-1:0] v = '0;
    for (int i = 0; i < BS; i++) v[i] = m_occ[i];
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < BS; i++) m_occ[i] = 1'b0;
    m_rv = 1'b0;
    m_re = 1'b0;
    m_rd = '0;
  endtask

  // Apply one clock edge to the model using the inputs presented before it.
  task automatic m_edge();
    int  slot;
    bit  wr;
    bit  legal;
    if (rst) begin
      m_reset();
      return;
    end
    wr = in_valid && (m_count() != BS);
    slot = -1;
    for (int i = BS - 1; i >= 0; i--) if (!m_occ[i]) slot = i;
    legal = rd_en && (int'(rd_index) < BS) && m_occ[rd_index];
    if (legal) begin
      m_rd = m_mem[rd_index];
      m_occ[rd_index] = 1'b0;
      m_rv = 1'b1;
      m_re = 1'b0;
    end else begin
      m_rv = 1'b0;
      m_re = rd_en;
    end
    if (wr) begin
      m_mem[slot] = in_data;
      m_occ[slot] = 1'b1;
    end
  endtask

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cand_list", 64'(cand_list), 64'(m_cand()));
      chk("count",     64'(count),     64'(m_count()));
      chk("full",      64'(full),      64'(m_count() == BS));
      chk("empty",     64'(empty),     64'(m_count() == 0));
      chk("in_ready",  64'(in_ready),  64'(!rst && (m_count() != BS)));
      chk("rd_valid",  64'(rd_valid),  64'(m_rv));
      chk("rd_err",    64'(rd_err),    64'(m_re));
      chk("rd_data",   64'(rd_data),   64'(m_rd));
    end
  end

  // One cycle: present inputs, let the edge happen, return at the falling edge.
  task automatic step(input bit iv, input logic [DW-1:0] d, input bit re, input logic [3:0] ri);
    in_valid = iv;
    in_data  = d;
    rd_en    = re;
    rd_index = ri;
    @(posedge clk);
    m_edge();
    @(negedge clk);
    in_valid = 1'b0;
    rd_en    = 1'b0;
  endtask

  initial begin
    m_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_cand",     64'(cand_list), 64'h0);
    chk("rst_count",    64'(count),     64'h0);
    chk("rst_empty",    64'(empty),     64'h1);
    chk("rst_in_ready", 64'(in_ready),  64'h0);
    chk("rst_rd_valid", 64'(rd_valid),  64'h0);
    chk("rst_rd_data",  64'(rd_data),   64'h0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Three writes fill slots 0..2.
    step(1'b1, 32'hA0, 1'b0, 4'd0);
    step(1'b1, 32'hA1, 1'b0, 4'd0);
    step(1'b1, 32'hA2, 1'b0, 4'd0);
    chk("three_cand",  64'(cand_list), 64'h0007);
    chk("three_count", 64'(count),     64'h3);
    chk("three_empty", 64'(empty),     64'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 4'(i));
    chk("drain3_data", 64'(rd_data), 64'hA2);

    // Fill all slots, then offer one more word.
    for (int i = 0; i < BS; i++) step(1'b1, 32'h100 + 32'(i), 1'b0, 4'd0);
    chk("fill_full",  64'(full),     64'h1);
    chk("fill_ready", 64'(in_ready), 64'h0);
    step(1'b1, 32'hDEAD, 1'b0, 4'd0);
    chk("over_count", 64'(count),     64'h10);
    chk("over_cand",  64'(cand_list), 64'hFFFF);

    // Read slot 5 from full, then the next write reuses slot 5.
    step(1'b0, 32'h0, 1'b1, 4'd5);
    chk("rd5_valid", 64'(rd_valid),  64'h1);
    chk("rd5_data",  64'(rd_data),   64'h105);
    chk("rd5_cand",  64'(cand_list), 64'hFFDF);
    chk("rd5_count", 64'(count),     64'hF);
    step(1'b1, 32'hBEEF, 1'b0, 4'd0);
    chk("beef_cand", 64'(cand_list), 64'hFFFF);
    step(1'b0, 32'h0, 1'b1, 4'd5);
    chk("beef_data", 64'(rd_data), 64'hBEEF);
    for (int i = 0; i < BS; i++) step(1'b0, 32'h0, 1'b1, 4'(i));
    chk("drain_empty", 64'(empty), 64'h1);

    // Simultaneous write and legal read with slots 0..2 occupied.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h10 + 32'(i), 1'b0, 4'd0);
    step(1'b1, 32'h55, 1'b1, 4'd1);
    chk("sim_data",  64'(rd_data),   64'h11);
    chk("sim_cand",  64'(cand_list), 64'h000D);
    chk("sim_count", 64'(count),     64'h3);

    // Read of an empty slot flags an error for exactly one cycle.
    step(1'b0, 32'h0, 1'b1, 4'd7);
    chk("err_pulse", 64'(rd_err),   64'h1);
    chk("err_valid", 64'(rd_valid), 64'h0);
    chk("err_data",  64'(rd_data),  64'h11);
    chk("err_count", 64'(count),    64'h3);
    step(1'b0, 32'h0, 1'b0, 4'd0);
    chk("err_clear", 64'(rd_err), 64'h0);

    // Four slots occupied and a read just completed, then async reset mid-cycle.
    step(1'b1, 32'h77, 1'b0, 4'd0);
    step(1'b1, 32'h88, 1'b1, 4'd3);
    chk("pre_rst_data", 64'(rd_data),   64'h55);
    chk("pre_rst_cand", 64'(cand_list), 64'h0017);
    in_valid = 1'b1;
    in_data  = 32'h1234;
    #2;
    rst = 1'b1;
    #1;
    m_reset();
    chk("arst_cand",  64'(cand_list), 64'h0);
    chk("arst_count", 64'(count),     64'h0);
    chk("arst_valid", 64'(rd_valid),  64'h0);
    @(posedge clk);
    m_edge();
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    step(1'b1, 32'h99, 1'b0, 4'd0);
    chk("post_rst_cand", 64'(cand_list), 64'h0001);

    // Randomized traffic checked against the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 50,
           4'($urandom_range(0, BS - 1)));
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/esm_buffer_writer.md
Name: esm_buffer_writer

Overview:
- Write-side counterpart of the ESM shared buffer's random-selection read path.
- Accepts incoming data words over a valid/ready handshake and stores each in the lowest-index free slot of a bs-entry buffer.
- Publishes the per-slot occupancy vector as cand_list, which drives the random mapping/selection logic.
- Serves reads at the buffer_index chosen by that logic and frees the slot on each read.

Parameters:
bs, 16, number of buffer slots (2..256, any value; need not be a power of two)
dw, 32, data word width in bits

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  producer has a word on in_data
in_data  in  dw  word to store
in_ready  out  1  buffer can accept a word this cycle
rd_en  in  1  read request from the selection side
rd_index  in  $clog2(bs)  slot to read (buffer_index from the selection logic)
rd_valid  out  1  rd_data holds a word read last cycle
rd_data  out  dw  read data, registered
cand_list  out  bs  bit i = 1 when slot i holds unread data
count  out  $clog2(bs)+1  number of occupied slots
full  out  1  count == bs
empty  out  1  count == 0
rd_err  out  1  one-cycle pulse: last read targeted an empty or out-of-range slot

Behaviour:
- Reset (async, active-high):
  - occupancy vector, count, rd_valid and rd_err cleared to 0; rd_data cleared to 0.
  - in_ready = 0 while rst is high, 1 after release.
  - Storage contents need not be cleared.
  - Reset asserted mid-transfer drops everything: no partial write or read completes.
- Outputs:
  - cand_list, count, full and empty are driven directly from registered state.
  - in_ready = !full, registered-state-derived only. It does not depend on rd_en in the same cycle; no same-cycle read-to-write bypass.
- Write path:
  - A transfer occurs when in_valid && in_ready at the clock edge.
  - The target slot is the lowest index i with occupancy[i] == 0, found by a combinational priority encoder over registered occupancy.
  - On the edge: mem[slot] <= in_data and occupancy[slot] <= 1.
- Read path:
  - A read is legal when rd_en == 1, rd_index < bs and occupancy[rd_index] == 1.
  - Legal read, on the edge: rd_data <= mem[rd_index], rd_valid <= 1, occupancy[rd_index] <= 0. Latency is 1 cycle.
  - Illegal read (rd_en == 1 otherwise): rd_valid <= 0, rd_err <= 1 for one cycle, rd_data holds its previous value, state unchanged.
  - rd_en == 0: rd_valid <= 0, rd_err <= 0, rd_data holds.
- Count update, same edge:
  - count <= count + write_fire - legal_read.
  - Never wraps; count stays within 0..bs by construction.
- Simultaneous write and legal read in the same cycle:
  - Both occur. They cannot target the same slot, because the write slot is free and the read slot is occupied.
  - Net count unchanged.
  - The freed slot becomes visible to the allocator only from the next cycle.
- Boundary cases:
  - Full plus read: in_ready is 0 that cycle; the freed slot is writable from the next cycle.
  - Empty: every read request is illegal and flags rd_err.
  - Writing after a slot is freed reuses the lowest free index, not a round-robin pointer.
- No FIFO ordering is implied. Order of departure is decided entirely by rd_index.

Test Plan:
- Reset, then 3 writes of 0xA0, 0xA1, 0xA2 -> slots 0, 1, 2 filled; cand_list = 0x0007, count = 3, empty = 0.
- Fill all 16 slots with values 0x100+i -> full = 1, in_ready = 0. A 17th in_valid is not accepted and no state changes.
- From full: rd_en with rd_index = 5 -> next cycle rd_valid = 1, rd_data = 0x105, cand_list = 0xFFDF, count = 15. The following write of 0xBEEF lands in slot 5.
- Same-cycle write of 0x55 and read of slot 1 with slots 0..2 occupied -> slot 1 read out, 0x55 stored in slot 3; count stays 3; cand_list = 0x000D.
- rd_en on empty slot 7 -> rd_err pulses 1 for one cycle, rd_valid = 0, rd_data unchanged, count unchanged.
- Assert rst asynchronously between edges with 4 slots occupied and a write pending -> cand_list = 0, count = 0, rd_valid = 0 immediately. After release, the first write goes to slot 0.
